// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
// Pointer widths carry one extra wrap bit beyond the storage address.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // One extra MSB lets full and empty be told apart when the addresses match.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit isPow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage with one synchronous write port and a registered read port.
// The read register resets to zero but holds its value whenever no read is enabled.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEn_i,
  input  logic [AW-1:0]    wrAddr_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic             rdEn_i,
  input  logic [AW-1:0]    rdAddr_i,
  output logic [WIDTH-1:0] rdData_o
);

  logic [WIDTH-1:0] memArray_q [DEPTH];
  logic [WIDTH-1:0] rdData_q;

  // Storage is left uninitialised so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      memArray_q[wrAddr_i] <= wrData_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdData_q <= '0;
    end else if (rdEn_i) begin
      rdData_q <= memArray_q[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO: wrap-bit pointers, occupancy count, status flags
// and sticky overflow/underflow errors around a block-RAM style storage array.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int PW       = ptrWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             en_write,
  input  logic [WIDTH-1:0] data_in,
  input  logic             en_read,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = PW - 1;

  if (!isPow2(DEPTH)) begin : gDepthCheck
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if (WIDTH < 1) begin : gWidthCheck
    $error("sync_fifo_param: WIDTH must be at least 1");
  end

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          dataValid_q, dataValid_d;
  logic          wrAccept;
  logic          rdAccept;

  // Flags decode the registered pointers only, so they never glitch within a cycle.
  assign full         = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
  assign empty        = (wrPtr_q == rdPtr_q);
  assign count        = wrPtr_q - rdPtr_q;
  assign almost_full  = (count >= PW'(AFULL_TH));
  assign almost_empty = (count <= PW'(AEMPTY_TH));

  // Acceptance uses the pre-edge flags, so a write into an empty FIFO is never readable the same cycle.
  assign wrAccept = en_write && !full && !flush;
  assign rdAccept = en_read && !empty && !flush;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    dataValid_d = 1'b0;
    if (flush) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wrAccept) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (rdAccept) begin
        rdPtr_d     = rdPtr_q + PW'(1);
        dataValid_d = 1'b1;
      end
      if (en_write && full) begin
        overflow_d = 1'b1;
      end
      if (en_read && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dataValid_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dataValid_q <= dataValid_d;
    end
  end

  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign data_valid = dataValid_q;

  // data_out lives in the memory's read register; flush deliberately leaves it alone.
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) uMem (
    .clk      (clk),
    .reset    (reset),
    .wrEn_i   (wrAccept),
    .wrAddr_i (wrPtr_q[AW-1:0]),
    .wrData_i (data_in),
    .rdEn_i   (rdAccept),
    .rdAddr_i (rdPtr_q[AW-1:0]),
    .rdData_o (data_out)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 14;
  localparam int AEMPTY_TH = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             en_write;
  logic [WIDTH-1:0] data_in;
  logic             en_read;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of words plus the registered/sticky outputs.
  logic [WIDTH-1:0] modelQ [$];
  logic [WIDTH-1:0] mDout;
  logic             mDv;
  logic             mOvf;
  logic             mUnf;

  typedef struct {
    logic             fl;
    logic             w;
    logic             r;
    logic [WIDTH-1:0] d;
    int               expCount;
    logic [WIDTH-1:0] expDout;
    logic             expDv;
    logic             expOvf;
    logic             expUnf;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .en_write     (en_write),
    .data_in      (data_in),
    .en_read      (en_read),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic void modelReset();
    modelQ.delete();
    mDout = '0;
    mDv   = 1'b0;
    mOvf  = 1'b0;
    mUnf  = 1'b0;
  endfunction

  function automatic void modelStep(input logic fl, input logic w, input logic r,
                                    input logic [WIDTH-1:0] d);
    int  sz;
    bit  canRead;
    bit  canWrite;
    sz       = modelQ.size();
    canRead  = (sz > 0);
    canWrite = (sz < DEPTH);
    if (fl) begin
      modelQ.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
      mDv  = 1'b0;
    end else begin
      mDv = 1'b0;
      if (r && canRead) begin
        mDout = modelQ.pop_front();
        mDv   = 1'b1;
      end
      if (r && !canRead) mUnf = 1'b1;
      if (w && canWrite) modelQ.push_back(d);
      if (w && !canWrite) mOvf = 1'b1;
    end
  endfunction

  task automatic checkOutput(input string tag);
    int sz;
    sz = modelQ.size();
    compare({tag, ".count"},        32'(count),        32'(sz));
    compare({tag, ".full"},         32'(full),         32'(sz == DEPTH));
    compare({tag, ".empty"},        32'(empty),        32'(sz == 0));
    compare({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AFULL_TH));
    compare({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AEMPTY_TH));
    compare({tag, ".data_valid"},   32'(data_valid),   32'(mDv));
    compare({tag, ".overflow"},     32'(overflow),     32'(mOvf));
    compare({tag, ".underflow"},    32'(underflow),    32'(mUnf));
    if (mDv) compare({tag, ".data_out"}, 32'(data_out), 32'(mDout));
  endtask

  // Inputs are driven at the falling edge, the model advances on the rising edge,
  // and outputs are sampled at the following falling edge.
  task automatic applyStimulus(input logic fl, input logic w, input logic r,
                               input logic [WIDTH-1:0] d, input string tag);
    flush    = fl;
    en_write = w;
    en_read  = r;
    data_in  = d;
    @(posedge clk);
    modelStep(fl, w, r, d);
    @(negedge clk);
    flush    = 1'b0;
    en_write = 1'b0;
    en_read  = 1'b0;
    checkOutput(tag);
  endtask

  task automatic fillTo(input int target, input string tag);
    while (modelQ.size() < target) applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'($urandom), tag);
    while (modelQ.size() > target) applyStimulus(1'b0, 1'b0, 1'b1, '0, tag);
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    en_write = 1'b0;
    en_read  = 1'b0;
    data_in  = '0;
    modelReset();

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h33, 2, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h22, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h33, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h44, 1, 8'h33, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h55, 0, 8'h33, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h33, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h66, 1, 8'h33, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h66, 1'b1, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    compare("reset.data_out", 32'(data_out), 32'h0);
    checkOutput("reset");

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].fl, vecs[i].w, vecs[i].r, vecs[i].d, $sformatf("vec%0d", i));
      compare($sformatf("vec%0d.tcount", i), 32'(count),      32'(vecs[i].expCount));
      compare($sformatf("vec%0d.tdout", i),  32'(data_out),   32'(vecs[i].expDout));
      compare($sformatf("vec%0d.tdv", i),    32'(data_valid), 32'(vecs[i].expDv));
      compare($sformatf("vec%0d.tovf", i),   32'(overflow),   32'(vecs[i].expOvf));
      compare($sformatf("vec%0d.tunf", i),   32'(underflow),  32'(vecs[i].expUnf));
    end

    // Fill and drain with a known ramp, then overflow/underflow at the extremes.
    fillTo(0, "pre_fill");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'(i), $sformatf("fill%0d", i));
      compare($sformatf("fill%0d.af", i), 32'(almost_full), 32'(i + 1 >= 14));
    end
    compare("fill.full", 32'(full), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hAA, "ovf_write");
    compare("ovf.count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, '0, $sformatf("drain%0d", i));
      compare($sformatf("drain%0d.dout", i), 32'(data_out), 32'(i));
      compare($sformatf("drain%0d.dv", i), 32'(data_valid), 32'h1);
    end
    compare("drain.empty", 32'(empty), 32'h1);
    compare("drain.ovf_sticky", 32'(overflow), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, "unf_read");
    compare("unf.flag", 32'(underflow), 32'h1);
    compare("unf.dv", 32'(data_valid), 32'h0);

    // Simultaneous traffic at count 5 and at full.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, "flush_a");
    fillTo(5, "to5");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, WIDTH'($urandom), $sformatf("rw5_%0d", i));
      compare($sformatf("rw5_%0d.count", i), 32'(count), 32'd5);
    end
    fillTo(DEPTH, "to_full");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A, "rw_full");
    compare("rw_full.count", 32'(count), 32'd15);
    compare("rw_full.ovf", 32'(overflow), 32'h1);

    // Wrap-around: 40 write/read pairs at count 8 cross the pointer wrap twice.
    fillTo(8, "to8");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'($urandom), $sformatf("wrap_w%0d", i));
      applyStimulus(1'b0, 1'b0, 1'b1, '0, $sformatf("wrap_r%0d", i));
    end

    // Flush at count 9 with overflow set, alongside a write that must be dropped.
    fillTo(DEPTH, "to_full2");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hEE, "ovf2");
    fillTo(9, "to9");
    compare("pre_flush.ovf", 32'(overflow), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hC3, "flush_w");
    compare("flush.count", 32'(count), 32'd0);
    compare("flush.empty", 32'(empty), 32'h1);
    compare("flush.ovf", 32'(overflow), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, "post_flush_w");
    applyStimulus(1'b0, 1'b0, 1'b1, '0, "post_flush_r");
    compare("post_flush.dout", 32'(data_out), 32'h3C);

    // Randomized traffic: fill-biased then drain-biased, with rare flushes.
    for (int i = 0; i < 400; i++) begin
      logic w, r, fl;
      w  = ($urandom_range(0, 99) < ((i % 100) < 50 ? 75 : 35));
      r  = ($urandom_range(0, 99) < ((i % 100) < 50 ? 35 : 75));
      fl = ($urandom_range(0, 199) == 0);
      applyStimulus(fl, w, r, WIDTH'($urandom), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of a clock phase, with data in flight.
    fillTo(6, "pre_reset");
    applyStimulus(1'b0, 1'b0, 1'b1, '0, "pre_reset_rd");
    en_write = 1'b1;
    data_in  = 8'h77;
    #2 reset = 1'b1;
    #1;
    compare("areset.empty",        32'(empty),        32'h1);
    compare("areset.count",        32'(count),        32'h0);
    compare("areset.almost_empty", 32'(almost_empty), 32'h1);
    compare("areset.data_out",     32'(data_out),     32'h0);
    compare("areset.data_valid",   32'(data_valid),   32'h0);
    compare("areset.overflow",     32'(overflow),     32'h0);
    #1 reset = 1'b0;
    en_write = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("post_reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h99, "first_after_reset");
    applyStimulus(1'b0, 1'b0, 1'b1, '0, "read_after_reset");
    compare("after_reset.dout", 32'(data_out), 32'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
